// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_mem_pkg                                                         |
// | Shared FSM encoding and sizing constants for the data-memory slave.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package riscv_mem_pkg;

  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int c_strb_w            = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_array                                                            |
// | Single-port word RAM, byte-lane writes, registered (synchronous) read.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dmem_array
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic                           clk,
  input  logic                           i_en,
  input  logic                           i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  input  logic [c_strb_w-1:0]            i_wstrb,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Read register only moves on reads, so writes leave the last read word intact.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < c_strb_w; b++) begin
          if (i_wstrb[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_responder                                                    |
// | Valid/ready data-memory slave with programmable wait states.          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_valid,
  input  logic                mem_wen,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [c_strb_w-1:0] mem_wstrb,
  output logic                mem_ready,
  output logic [31:0]         mem_rdata,
  output logic                mem_err
);

  localparam int         c_aw        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_wait_load = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic                  w_fire;

  logic                  r_wen;
  logic [29:0]           r_word;
  logic [31:0]           r_wdata;
  logic [c_strb_w-1:0]   r_wstrb;

  logic                  w_idle;
  logic                  w_req_wen;
  logic [29:0]           w_req_word;
  logic [31:0]           w_req_wdata;
  logic [c_strb_w-1:0]   w_req_wstrb;
  logic                  w_in_range;
  logic                  w_ram_en;
  logic [31:0]           w_ram_rdata;

  logic                  r_err;
  logic                  r_rd_valid;

  logic                  w_unused;
  assign w_unused = &{1'b0, mem_addr[1:0]};

  // With zero wait states the RAM access happens on the accepting edge, before
  // the latched copy exists, so the live inputs are used while idle.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_req_wen   = w_idle ? mem_wen          : r_wen;
  assign w_req_word  = w_idle ? mem_addr[31:2]   : r_word;
  assign w_req_wdata = w_idle ? mem_wdata        : r_wdata;
  assign w_req_wstrb = w_idle ? mem_wstrb        : r_wstrb;
  assign w_in_range  = (w_req_word[29:c_aw] == '0);
  assign w_ram_en    = w_fire && w_in_range && !reset;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (mem_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ST_RESP;
            w_fire      = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = c_wait_load;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
          w_fire      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_idle && mem_valid && !reset) begin
      r_wen   <= mem_wen;
      r_word  <= mem_addr[31:2];
      r_wdata <= mem_wdata;
      r_wstrb <= mem_wstrb;
    end
  end

  // r_rd_valid gates the RAM read register so reset and out-of-range reads show zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_err <= w_fire && !w_in_range;
      if (w_fire && !w_req_wen) begin
        r_rd_valid <= w_in_range;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_dmem_array (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_req_wen),
    .i_addr  (w_req_word[c_aw-1:0]),
    .i_wdata (w_req_wdata),
    .i_wstrb (w_req_wstrb),
    .o_rdata (w_ram_rdata)
  );

  assign mem_ready = (r_state == ST_RESP);
  assign mem_err   = r_err;
  assign mem_rdata = r_rd_valid ? w_ram_rdata : 32'd0;

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: word-addressed storage depth, power of two, 4..65536.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0: extra wait states inserted before each response, 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_valid  input  1  initiator request strobe, held until mem_ready.
REQ-006 SHALL have port mem_wen  input  1  1 = write, 0 = read.
REQ-007 SHALL have port mem_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port mem_wdata  input  32  write data, lane-aligned.
REQ-009 SHALL have port mem_wstrb  input  4  byte-lane write enables; bit n covers bits [8n+7:8n].
REQ-010 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port mem_rdata  output  32  read data, valid while mem_ready is high after a read.
REQ-012 SHALL have port mem_err  output  1  out-of-range flag, pulses with mem_ready.

Function
REQ-013 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly when WAIT_CYCLES = 0.
REQ-014 SHALL accept a request in IDLE on any edge where mem_valid = 1; it SHALL latch addr, wdata, wstrb and wen at that edge.
REQ-015 SHALL use only latched request fields afterwards; changes to inputs after acceptance SHALL have no effect.
REQ-016 SHALL stay in WAIT for exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter.
REQ-017 SHALL hold mem_ready = 1 for exactly the one cycle spent in RESP. Latency from the accepting edge to mem_ready high SHALL be WAIT_CYCLES + 1 cycles.
REQ-018 SHALL ignore mem_valid while in WAIT or RESP. A valid still asserted in RESP SHALL therefore not re-accept, which guarantees at least one IDLE cycle between transactions.
REQ-019 SHALL commit a write on the edge entering RESP, updating only lanes with wstrb = 1.
REQ-020 SHALL treat wstrb = 0000 as a no-op write that still completes with mem_ready.
REQ-021 SHALL drive mem_rdata on a read from the full word at addr[31:2], sampled on the edge entering RESP. A write issued immediately before the read SHALL therefore be visible to that read.
REQ-022 SHALL leave mem_rdata unchanged by write transactions and hold it between transactions.
REQ-023 SHALL treat addr[31:2] >= DEPTH_WORDS as out of range. Such a request SHALL perform no write, return mem_rdata = 0 on a read, and assert mem_err with mem_ready.
REQ-024 SHALL hold mem_err low at all times other than an out-of-range RESP cycle.
REQ-025 SHALL complete an accepted transaction even if mem_valid drops during WAIT.

Reset
REQ-026 SHALL on reset set FSM = IDLE, counter = 0, mem_ready = 0, mem_err = 0, mem_rdata = 0.
REQ-027 SHALL NOT clear storage contents on reset.
REQ-028 SHALL abort any in-flight transaction when reset is asserted mid-operation; an uncommitted write SHALL NOT occur, and no mem_ready SHALL follow.
REQ-029 SHALL give reset priority over mem_valid on the same edge.

Structure
REQ-030 SHALL place FSM state encoding, a DEFAULT_DEPTH_WORDS constant and a strobe-width constant (4) in shared package riscv_mem_pkg.
REQ-031 SHALL implement storage in sub-module dmem_array: a single-port, byte-lane-write, synchronous-read word RAM parameterised by depth.

Verification
REQ-032 SHALL cover: WAIT_CYCLES=0, write 0x00000014 wstrb=1111 at addr 0, then read addr 0 -> mem_ready pulses 1 cycle after each accept, and rdata = 0x00000014.
REQ-033 SHALL cover: word 1 preset to 0xAABBCCDD, write 0x000000FF wstrb=0001 at addr 4, then read -> rdata = 0xAABBCCFF.
REQ-034 SHALL cover: WAIT_CYCLES=3, read held valid -> ready exactly 4 cycles after accept, and no second ready while valid stays high through RESP.
REQ-035 SHALL cover: DEPTH_WORDS=256, read at addr 0x400 -> mem_err = 1 and mem_ready = 1 for one cycle, rdata = 0; the same write leaves word 0 unchanged.
REQ-036 SHALL cover: WAIT_CYCLES=3, write accepted, then reset asserted in the 2nd WAIT cycle -> no mem_ready, word unchanged, outputs at reset values.
REQ-037 SHALL cover: mem_valid dropped one cycle after accept with WAIT_CYCLES=2 -> transaction still completes, ready 3 cycles after accept.
